// File: rtl/ft245_pkg.sv
// ============================================================================
// ft245_pkg : shared FSM encoding, default timing and arbitration constants
//             for the FT245 FIFO bridge.
// Rev 1.0
// ============================================================================
`default_nettype none

package ft245_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_LOW   = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_LOW   = 3'd3,
        ST_RECOVER  = 3'd4
    } ft_state_t;

    localparam int c_DEF_DATA_W      = 8;
    localparam int c_DEF_TX_DEPTH    = 16;
    localparam int c_DEF_RX_DEPTH    = 16;
    localparam int c_DEF_SYNC_STAGES = 2;
    localparam int c_DEF_RD_PULSE    = 4;
    localparam int c_DEF_WR_SETUP    = 1;
    localparam int c_DEF_WR_PULSE    = 4;
    localparam int c_DEF_RECOVERY    = 2;

    localparam int c_ARB_RX_PRIO     = 0;
    localparam int c_ARB_ROUND_ROBIN = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, power-of-2 depth, extra-MSB pointers,
//             combinational head, no empty bypass.
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [c_AW:0]     wr_ptr_q;
    logic [c_AW:0]     rd_ptr_q;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[c_AW-1:0]];

    // A simultaneous pop frees the slot, so a push is still taken when full.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[c_AW-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/ft245_fifo_bridge.sv
// ============================================================================
// ft245_fifo_bridge : SoC valid/ready streams <-> FT245-style async USB FIFO,
//                     with flag synchronisers, strobe timing FSM and buffering.
// Rev 1.0
// ============================================================================
`default_nettype none

module ft245_fifo_bridge
    import ft245_pkg::*;
#(
    parameter int DATA_W      = c_DEF_DATA_W,
    parameter int TX_DEPTH    = c_DEF_TX_DEPTH,
    parameter int RX_DEPTH    = c_DEF_RX_DEPTH,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES,
    parameter int RD_PULSE    = c_DEF_RD_PULSE,
    parameter int WR_SETUP    = c_DEF_WR_SETUP,
    parameter int WR_PULSE    = c_DEF_WR_PULSE,
    parameter int RECOVERY    = c_DEF_RECOVERY,
    parameter int ARB_MODE    = c_ARB_RX_PRIO
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ft_rxf_n,
    input  logic                        ft_txe_n,
    input  logic [DATA_W-1:0]           ft_din,
    output logic [DATA_W-1:0]           ft_dout,
    output logic                        ft_oe,
    output logic                        ft_rd_n,
    output logic                        ft_wr_n,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    localparam int c_REC_CYCLES = RECOVERY + SYNC_STAGES;
    localparam int c_CNT_MAX    = max2(max2(RD_PULSE, WR_SETUP), max2(WR_PULSE, c_REC_CYCLES));
    localparam int c_CNT_W      = max2($clog2(c_CNT_MAX), 1);

    logic [SYNC_STAGES-1:0] rxf_sync_q;
    logic [SYNC_STAGES-1:0] txe_sync_q;

    ft_state_t              state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic                   last_wr_q, last_wr_d;
    logic                   rd_n_q, rd_n_d;
    logic                   wr_n_q, wr_n_d;
    logic                   oe_q, oe_d;
    logic [DATA_W-1:0]      dout_q, dout_d;

    logic                   w_srxf_n;
    logic                   w_stxe_n;
    logic                   w_rd_req;
    logic                   w_wr_req;
    logic                   w_rr_mode;
    logic                   w_do_rd;
    logic                   w_do_wr;
    logic                   w_tx_push;
    logic                   w_tx_pop;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic [DATA_W-1:0]      w_tx_head;
    logic                   w_rx_push;
    logic                   w_rx_pop;
    logic                   w_rx_full;
    logic                   w_rx_empty;

    // Flags reset to the inactive (high) level so nothing fires out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxf_sync_q <= '1;
            txe_sync_q <= '1;
        end else begin
            rxf_sync_q <= {rxf_sync_q[SYNC_STAGES-2:0], ft_rxf_n};
            txe_sync_q <= {txe_sync_q[SYNC_STAGES-2:0], ft_txe_n};
        end
    end

    assign w_srxf_n = rxf_sync_q[SYNC_STAGES-1];
    assign w_stxe_n = txe_sync_q[SYNC_STAGES-1];

    assign w_rd_req  = ~w_srxf_n & ~w_rx_full;
    assign w_wr_req  = ~w_stxe_n & ~w_tx_empty;
    assign w_rr_mode = (ARB_MODE == c_ARB_ROUND_ROBIN);
    assign w_do_rd   = w_rd_req & (~w_wr_req | ~w_rr_mode | last_wr_q);
    assign w_do_wr   = w_wr_req & ~w_do_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        dout_d    = dout_q;
        w_rx_push = 1'b0;
        w_tx_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_do_rd) begin
                    state_d   = ST_RD_LOW;
                    cnt_d     = c_CNT_W'(RD_PULSE - 1);
                    last_wr_d = 1'b0;
                end else if (w_do_wr) begin
                    state_d   = ST_WR_SETUP;
                    cnt_d     = c_CNT_W'(WR_SETUP - 1);
                    last_wr_d = 1'b1;
                    w_tx_pop  = 1'b1;
                    dout_d    = w_tx_head;
                end
            end
            ST_RD_LOW: begin
                // The pad bus is captured on the final low cycle of RD#.
                if (cnt_q == '0) begin
                    w_rx_push = 1'b1;
                    state_d   = ST_RECOVER;
                    cnt_d     = c_CNT_W'(c_REC_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_LOW;
                    cnt_d   = c_CNT_W'(WR_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            ST_WR_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                    cnt_d   = c_CNT_W'(c_REC_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Strobes are registered from the state being entered; the bus is
        // held for one extra cycle after WR# rises.
        rd_n_d = (state_d != ST_RD_LOW);
        wr_n_d = (state_d != ST_WR_LOW);
        oe_d   = (state_d == ST_WR_SETUP) || (state_d == ST_WR_LOW) ||
                 ((state_q == ST_WR_LOW) && (state_d == ST_RECOVER));
    end

    assign ft_rd_n  = rd_n_q;
    assign ft_wr_n  = wr_n_q;
    assign ft_oe    = oe_q;
    assign ft_dout  = dout_q;

    assign tx_ready  = ~w_tx_full;
    assign w_tx_push = tx_valid & tx_ready;
    assign rx_valid  = ~w_rx_empty;
    assign w_rx_pop  = rx_valid & rx_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_tx_push),
        .push_data_i (tx_data),
        .pop_i       (w_tx_pop),
        .head_o      (w_tx_head),
        .full_o      (w_tx_full),
        .empty_o     (w_tx_empty),
        .level_o     (tx_level)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_rx_push),
        .push_data_i (ft_din),
        .pop_i       (w_rx_pop),
        .head_o      (rx_data),
        .full_o      (w_rx_full),
        .empty_o     (w_rx_empty),
        .level_o     (rx_level)
    );

endmodule

`default_nettype wire
